// File: rtl/audio_pwm_capture_4chan.sv
// Receive side of the 4-channel time-multiplexed PWM audio line: recovers per-slot pulsewidths.
// Optional PWM shape checker enabled by defining PWM_CAPTURE_SHAPE_CHECK_EN.
`ifndef BITRES
`define BITRES 4
`endif

module audio_pwm_capture_4chan #(
  parameter int SYNC_SKEW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mute,
  input  logic                audin,
  output logic [`BITRES-1:0]  pulsewidth0,
  output logic [`BITRES-1:0]  pulsewidth1,
  output logic [`BITRES-1:0]  pulsewidth2,
  output logic [`BITRES-1:0]  pulsewidth3,
  output logic [3:0]          chan_valid,
  output logic                frame_valid,
  output logic                shape_err
);
  localparam int B = `BITRES;
  localparam logic [1:0]   SKEW_INIT = 2'(SYNC_SKEW);
  localparam logic [B+1:0] PH_ONE    = (B+2)'(1);

  typedef enum logic {ALIGN, RUN} state_t;

  state_t         state_reg, state_next;
  logic [B+1:0]   phase_reg;
  logic [B:0]     acc_reg;
  logic [1:0]     skew_reg;
  logic [B-1:0]   width_reg [4];
  logic           active;
  logic [1:0]     slot;
  logic           slot_end;
  logic [B:0]     sum;
  logic [B-1:0]   sat_sum;

  assign slot     = phase_reg[B+1:B];
  assign slot_end = &phase_reg[B-1:0];
  assign sum      = acc_reg + {{B{1'b0}}, audin};
  // A line stuck high for a whole slot counts one past the field width.
  assign sat_sum  = sum[B] ? {B{1'b1}} : sum[B-1:0];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ALIGN;
    else       state_reg <= state_next;
  end

  // Once the skew counter has drained, the ALIGN cycle itself is the first sampled RUN cycle.
  always_comb begin
    state_next = state_reg;
    active     = 1'b0;
    if (mute) begin
      state_next = ALIGN;
    end else if (state_reg == RUN || skew_reg == 2'd0) begin
      state_next = RUN;
      active     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg  <= '0;
      acc_reg    <= '0;
      skew_reg   <= SKEW_INIT;
      chan_valid <= '0;
      for (int i = 0; i < 4; i++) width_reg[i] <= '0;
    end else begin
      chan_valid <= '0;
      if (mute) begin
        phase_reg <= '0;
        acc_reg   <= '0;
        skew_reg  <= SKEW_INIT;
      end else if (!active) begin
        skew_reg <= skew_reg - 2'd1;
      end else begin
        phase_reg <= phase_reg + PH_ONE;
        if (slot_end) begin
          width_reg[slot]  <= sat_sum;
          chan_valid[slot] <= 1'b1;
          acc_reg          <= '0;
        end else begin
          acc_reg <= sum;
        end
      end
    end
  end

  assign pulsewidth0 = width_reg[0];
  assign pulsewidth1 = width_reg[1];
  assign pulsewidth2 = width_reg[2];
  assign pulsewidth3 = width_reg[3];
  assign frame_valid = chan_valid[3];

`ifdef PWM_CAPTURE_SHAPE_CHECK_EN
  logic seen_low_reg;
  logic seen_low_eff;

  // The first sample of a slot starts with a clean history.
  assign seen_low_eff = (phase_reg[B-1:0] == '0) ? 1'b0 : seen_low_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_low_reg <= 1'b0;
      shape_err    <= 1'b0;
    end else if (mute) begin
      seen_low_reg <= 1'b0;
    end else if (active) begin
      seen_low_reg <= seen_low_eff | ~audin;
      if (audin && seen_low_eff) shape_err <= 1'b1;
    end
  end
`else
  assign shape_err = 1'b0;
`endif

endmodule

// File: tb/tb_audio_pwm_capture_4chan.sv
// Scoreboard bench for audio_pwm_capture_4chan: driver pushes expected slot captures, monitor checks strobes.
`ifndef BITRES
`define BITRES 4
`endif

module tb_audio_pwm_capture_4chan;
  localparam int B    = `BITRES;
  localparam int SLOT = 1 << B;
  localparam int MAXW = SLOT - 1;
`ifdef PWM_CAPTURE_SHAPE_CHECK_EN
  localparam bit SHAPE_EN = 1'b1;
`else
  localparam bit SHAPE_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, mute = 1'b1, audin = 1'b0;
  logic [B-1:0] pulsewidth0, pulsewidth1, pulsewidth2, pulsewidth3;
  logic [3:0] chan_valid;
  logic frame_valid, shape_err;

  audio_pwm_capture_4chan #(.SYNC_SKEW(1)) dut (
    .clk(clk), .reset(reset), .mute(mute), .audin(audin),
    .pulsewidth0(pulsewidth0), .pulsewidth1(pulsewidth1),
    .pulsewidth2(pulsewidth2), .pulsewidth3(pulsewidth3),
    .chan_valid(chan_valid), .frame_valid(frame_valid), .shape_err(shape_err)
  );

  always #5 clk = ~clk;

  typedef struct { int chan; int w; int cyc; } exp_t;
  exp_t exp_q[$];
  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  int last_c0_cyc = -1;
  int rel_cyc = 0;
  bit exp_shape = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int pw_of(input int ch);
    case (ch)
      0: return int'(pulsewidth0);
      1: return int'(pulsewidth1);
      2: return int'(pulsewidth2);
      default: return int'(pulsewidth3);
    endcase
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (chan_valid != 4'd0 || frame_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", int'({chan_valid, frame_valid}), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("chan_valid slot%0d", e.chan), int'(chan_valid), 1 << e.chan);
        chk($sformatf("width slot%0d", e.chan), pw_of(e.chan), e.w);
        chk($sformatf("frame_valid slot%0d", e.chan), int'(frame_valid), int'(e.chan == 3));
        chk($sformatf("strobe_cycle slot%0d", e.chan), cyc, e.cyc);
        if (e.chan == 0) last_c0_cyc = cyc;
        $display("slot%0d captured width %0d at cyc %0d", e.chan, pw_of(e.chan), cyc);
      end
    end
  end

  task automatic idle(input bit m, input int n);
    for (int i = 0; i < n; i++) begin
      mute = m; audin = 1'($urandom);
      @(negedge clk);
    end
  endtask

  // First cycle after mute falls is discarded by the receiver (transmitter register latency).
  task automatic release_mute();
    rel_cyc = cyc;
    mute = 1'b0; audin = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic send_slot(input int s, input logic [SLOT-1:0] pat, input int nsamp);
    bit seen0 = 1'b0;
    int c, w;
    c = $countones(pat);
    w = (c > MAXW) ? MAXW : c;
    for (int i = 0; i < nsamp; i++) begin
      mute = 1'b0; audin = pat[i];
      if (SHAPE_EN && pat[i] && seen0) exp_shape = 1'b1;
      if (!pat[i]) seen0 = 1'b1;
      if (i == SLOT - 1) exp_q.push_back('{chan: s, w: w, cyc: cyc + 1});
      @(negedge clk);
      chk("shape_err", int'(shape_err), int'(exp_shape));
    end
  endtask

  function automatic logic [SLOT-1:0] pwm_pat(input int w);
    logic [SLOT:0] one = 1;
    logic [SLOT:0] t;
    t = (one << w) - 1;
    return t[SLOT-1:0];
  endfunction

  task automatic send_widths(input int w0, input int w1, input int w2, input int w3);
    send_slot(0, pwm_pat(w0), SLOT);
    send_slot(1, pwm_pat(w1), SLOT);
    send_slot(2, pwm_pat(w2), SLOT);
    send_slot(3, pwm_pat(w3), SLOT);
    $display("frame sent widths %0d %0d %0d %0d", w0, w1, w2, w3);
  endtask

  task automatic check_reset_state();
    chk("reset pw0", int'(pulsewidth0), 0);
    chk("reset pw1", int'(pulsewidth1), 0);
    chk("reset pw2", int'(pulsewidth2), 0);
    chk("reset pw3", int'(pulsewidth3), 0);
    chk("reset chan_valid", int'(chan_valid), 0);
    chk("reset frame_valid", int'(frame_valid), 0);
    chk("reset shape_err", int'(shape_err), 0);
  endtask

  initial begin
    logic [SLOT-1:0] p;
    @(negedge clk);
    reset = 1'b1; mute = 1'b1;
    idle(1'b1, 3);
    reset = 1'b0;
    idle(1'b1, 2);
    exp_shape = 1'b0;
    check_reset_state();

    // Directed first frame and latency from mute release.
    release_mute();
    send_widths(0, 5, MAXW, 8);
    chk("first chan0 latency", last_c0_cyc - rel_cyc, SLOT + 1);

    // Random legal frames, width 0 changes from 3 to 12 across frames.
    send_widths(3, 7, 1, 9);
    send_widths(12, 7, 1, 9);
    for (int f = 0; f < 5; f++)
      send_widths($urandom_range(0, MAXW), $urandom_range(0, MAXW),
                  $urandom_range(0, MAXW), $urandom_range(0, MAXW));

    // Mute at phase 20: slot 0 completes, slot 1 is aborted with no strobe.
    send_slot(0, pwm_pat($urandom_range(0, MAXW)), SLOT);
    send_slot(1, pwm_pat(MAXW), 4);
    idle(1'b1, 10);
    chk("queue empty after abort", exp_q.size(), 0);
    release_mute();
    send_widths($urandom_range(0, MAXW), 2, 11, $urandom_range(0, MAXW));
    chk("realign chan0 latency", last_c0_cyc - rel_cyc, SLOT + 1);

    // Line stuck high saturates every slot.
    p = '1;
    for (int s = 0; s < 4; s++) send_slot(s, p, SLOT);

    // Pattern 1,1,0,1,0... in slot 2: shape error (option) and raw count 3.
    send_slot(0, pwm_pat(4), SLOT);
    send_slot(1, pwm_pat(6), SLOT);
    p = '0; p[0] = 1'b1; p[1] = 1'b1; p[3] = 1'b1;
    send_slot(2, p, SLOT);
    send_slot(3, pwm_pat(2), SLOT);
    idle(1'b1, 5);
    chk("shape_err survives mute", int'(shape_err), int'(exp_shape));
    reset = 1'b1;
    idle(1'b1, 2);
    reset = 1'b0;
    exp_shape = 1'b0;
    idle(1'b1, 1);
    check_reset_state();

    // Random arbitrary patterns, legal or not.
    release_mute();
    for (int f = 0; f < 4; f++)
      for (int s = 0; s < 4; s++) begin
        p = SLOT'($urandom);
        send_slot(s, p, SLOT);
      end
    idle(1'b1, 4);
    chk("queue drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
